xbus_mxm_wr_par: RTL and testbench
==================================

XBUS_MXM_WR_PAR -- requirements
Module: xbus_mxm_wr_par

Interface
REQ-001 SHALL have parameter P, default 64: number of vector FIFO lanes.
REQ-002 SHALL have parameter S, default 8: bytes per FIFO word.
REQ-003 SHALL have parameter W, default 2: bytes per lane per MXM beat; N = S/W beats per vector.
REQ-004 SHALL have parameter RD_LAT, default 1: FIFO read latency in cycles, rd_en to valid dout, range 1..4.
REQ-005 SHALL have parameter OUT_REGS, default 0: extra output pipeline stages, range 0..3.
REQ-006 SHALL have port clk, input, 1: sole clock, all logic rising-edge.
REQ-007 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port vec_fifos_rd_en, output, P: read strobe per lane.
REQ-009 SHALL have port vec_fifos_dout, input, P*S*8: lane i word at bits [i*S*8 +: S*8].
REQ-010 SHALL have port vec_fifos_empty, input, P: empty flag per lane.
REQ-011 SHALL have port mxm_wr_en, output, 1: MXM write strobe.
REQ-012 SHALL have port mxm_din, output, P*W*8: MXM write data, lane i at [i*W*8 +: W*8].
REQ-013 SHALL have port mxm_prog_full, input, 1: MXM programmable-full backpressure.
REQ-014 SHALL have port busy, output, 1: high while a vector is in flight, in WAIT or SEND.
REQ-015 SHALL have port vec_cnt, output, 32: count of fully emitted vectors.

Function
REQ-016 SHALL fail elaboration ($error, $finish) unless S%W==0, N>=2, and RD_LAT and OUT_REGS are within range.
REQ-017 SHALL implement the FSM IDLE -> WAIT -> SEND -> IDLE.
REQ-018 In IDLE, when all vec_fifos_empty bits are 0, SHALL assert all P vec_fifos_rd_en bits together for exactly one cycle, then enter WAIT; rd_en bits SHALL never differ from each other.
REQ-019 WAIT SHALL last RD_LAT cycles; on the cycle dout is valid, SHALL latch vec_fifos_dout into a hold register and enter SEND with beat index k=0.
REQ-020 In SEND, each cycle with mxm_prog_full==0 SHALL issue beat k and increment k; each cycle with mxm_prog_full==1 SHALL issue nothing and hold k.
REQ-021 Beat k SHALL carry, for each lane i, hold bytes [k*W, k*W+W-1] of lane i; beats SHALL go out in ascending k.
REQ-022 After issuing beat N-1, SHALL increment vec_cnt and return to IDLE.
REQ-023 A beat SHALL appear on mxm_wr_en/mxm_din 1+OUT_REGS cycles after its issue cycle; mxm_din SHALL be held (not zeroed) when mxm_wr_en==0.
REQ-024 Per-vector cost without backpressure SHALL be N+RD_LAT+1 cycles; there SHALL be no reads while busy.
REQ-025 mxm_prog_full SHALL NOT gate reads in IDLE; it SHALL gate only beat issue.
REQ-026 Any lane empty in IDLE SHALL produce no read; partial-lane reads SHALL never occur.
REQ-027 vec_cnt SHALL wrap from 2^32-1 to 0.
REQ-028 A change of vec_fifos_dout outside the valid cycle SHALL NOT affect emitted data.

Reset
REQ-029 While rst_n==0: state=IDLE, k=0, hold register cleared, vec_fifos_rd_en=0, mxm_wr_en=0, mxm_din=0, all OUT_REGS stages cleared, busy=0, vec_cnt=0.
REQ-030 Assertion mid-vector SHALL discard the held vector and all pipelined beats; no partial beat SHALL emerge after release.
REQ-031 The first read SHALL occur no earlier than the first rising edge after rst_n deasserts.

Verification
REQ-032 Test single vector: P=4,S=8,W=2,RD_LAT=1, lane i word=bytes{i*8+7..i*8}, no prog_full -> rd_en pulse 1 cycle, 4 consecutive wr_en beats, beat k lane i = bytes {i*8+2k+1, i*8+2k}, vec_cnt=1.
REQ-033 Test backpressure: prog_full high for 3 cycles after beat 1 -> beats 0,1 then 3-cycle gap, then beats 2,3 in order, no loss or duplication.
REQ-034 Test lane empty: lane 2 empty for 10 cycles, others full -> no rd_en for 10 cycles, then all lanes read together.
REQ-035 Test reset mid-SEND: rst_n low after beat 1 -> outputs 0 immediately, after release no beats 2,3, vec_cnt=0.
REQ-036 Test config sweep: S=8,W=4,RD_LAT=3,OUT_REGS=2, 100 back-to-back vectors against a scoreboard -> 200 beats, each vector 6 cycles, outputs lagging issue by 3 cycles, vec_cnt=100.
REQ-037 Test illegal config: S=8,W=3 -> elaboration error.

Source files
------------

// File: rtl/xbus_mxm_wr_par.sv
// Vector FIFO to MXM write-port serializer: reads one word from every lane at
// once, then streams it out as S/W narrow beats with prog_full backpressure.
module xbus_mxm_wr_par #(
    parameter int P        = 64,
    parameter int S        = 8,
    parameter int W        = 2,
    parameter int RD_LAT   = 1,
    parameter int OUT_REGS = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [P-1:0]         vec_fifos_rd_en,
    input  logic [P*S*8-1:0]     vec_fifos_dout,
    input  logic [P-1:0]         vec_fifos_empty,
    output logic                 mxm_wr_en,
    output logic [P*W*8-1:0]     mxm_din,
    input  logic                 mxm_prog_full,
    output logic                 busy,
    output logic [31:0]          vec_cnt
);
    localparam int N  = S / W;
    localparam int KW = (N > 2) ? $clog2(N) : 1;
    localparam int LB = S * 8;
    localparam int BB = W * 8;

    generate
        if ((S % W) != 0 || N < 2 || RD_LAT < 1 || RD_LAT > 4 || OUT_REGS < 0 || OUT_REGS > 3) begin : g_cfg_err
            $error("xbus_mxm_wr_par: illegal parameters S=%0d W=%0d RD_LAT=%0d OUT_REGS=%0d",
                   S, W, RD_LAT, OUT_REGS);
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, WAIT, SEND} state_t;

    state_t             state_reg, state_next;
    logic [KW-1:0]      k_reg;
    logic [1:0]         wait_reg;
    logic               armed_reg;
    logic [P*S*8-1:0]   hold_reg;
    logic [31:0]        vec_cnt_reg;
    logic               rd_go, latch, issue, last_beat;
    logic [P*BB-1:0]    beat;
    logic               wr_pipe  [0:OUT_REGS];
    logic [P*BB-1:0]    din_pipe [0:OUT_REGS];

    assign last_beat = (k_reg == KW'(N - 1));

    always_comb begin
        state_next = state_reg;
        rd_go      = 1'b0;
        latch      = 1'b0;
        issue      = 1'b0;
        case (state_reg)
            IDLE: begin
                // armed_reg holds off the first read until a clock edge after reset release
                if (armed_reg && ~|vec_fifos_empty) begin
                    rd_go      = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (wait_reg == 2'(RD_LAT - 1)) begin
                    latch      = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (!mxm_prog_full) begin
                    issue = 1'b1;
                    if (last_beat) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            k_reg       <= '0;
            wait_reg    <= '0;
            armed_reg   <= 1'b0;
            hold_reg    <= '0;
            vec_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            armed_reg <= 1'b1;
            wait_reg  <= (state_reg == WAIT) ? wait_reg + 2'd1 : 2'd0;
            if (latch) begin
                hold_reg <= vec_fifos_dout;
                k_reg    <= '0;
            end else if (issue) begin
                k_reg <= last_beat ? '0 : k_reg + KW'(1);
            end
            if (issue && last_beat) begin
                vec_cnt_reg <= vec_cnt_reg + 32'd1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < P; gi++) begin : g_lane
            assign beat[gi*BB +: BB] = hold_reg[gi*LB + int'(k_reg)*BB +: BB];
        end
    endgenerate

    // Data registers load only on issue so mxm_din keeps the last beat between writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s <= OUT_REGS; s++) begin
                wr_pipe[s]  <= 1'b0;
                din_pipe[s] <= '0;
            end
        end else begin
            wr_pipe[0] <= issue;
            if (issue) begin
                din_pipe[0] <= beat;
            end
            for (int s = 1; s <= OUT_REGS; s++) begin
                wr_pipe[s]  <= wr_pipe[s-1];
                din_pipe[s] <= din_pipe[s-1];
            end
        end
    end

    assign vec_fifos_rd_en = {P{rd_go}};
    assign mxm_wr_en       = wr_pipe[OUT_REGS];
    assign mxm_din         = din_pipe[OUT_REGS];
    assign busy            = (state_reg != IDLE);
    assign vec_cnt         = vec_cnt_reg;

endmodule

// File: tb/tb_xbus_mxm_wr_par.sv
// Bench for xbus_mxm_wr_par: two configurations driven from bench FIFO models,
// emitted beats checked against a scoreboard of expected data and arrival cycle.
module tb_xbus_mxm_wr_par;
    localparam int PA = 4, SA = 8, WA = 2, RA = 1, OA = 0, NA = 4;
    localparam int PB = 4, SB = 8, WB = 4, RB = 3, OB = 2, NB = 2;

    typedef struct {
        logic [127:0] data;
        int           cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // A: P=4 S=8 W=2 RD_LAT=1 OUT_REGS=0
    logic [PA-1:0]      rd_en_a, empty_a, force_a;
    logic [PA*SA*8-1:0] dout_a;
    logic               wr_en_a, pf_a, busy_a;
    logic [PA*WA*8-1:0] din_a;
    logic [31:0]        vec_cnt_a;
    // B: P=4 S=8 W=4 RD_LAT=3 OUT_REGS=2
    logic [PB-1:0]      rd_en_b, empty_b;
    logic [PB*SB*8-1:0] dout_b;
    logic               wr_en_b, pf_b, busy_b;
    logic [PB*WB*8-1:0] din_b;
    logic [31:0]        vec_cnt_b;

    xbus_mxm_wr_par #(.P(PA), .S(SA), .W(WA), .RD_LAT(RA), .OUT_REGS(OA)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .vec_fifos_rd_en(rd_en_a), .vec_fifos_dout(dout_a), .vec_fifos_empty(empty_a),
        .mxm_wr_en(wr_en_a), .mxm_din(din_a), .mxm_prog_full(pf_a),
        .busy(busy_a), .vec_cnt(vec_cnt_a)
    );

    xbus_mxm_wr_par #(.P(PB), .S(SB), .W(WB), .RD_LAT(RB), .OUT_REGS(OB)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .vec_fifos_rd_en(rd_en_b), .vec_fifos_dout(dout_b), .vec_fifos_empty(empty_b),
        .mxm_wr_en(wr_en_b), .mxm_din(din_b), .mxm_prog_full(pf_b),
        .busy(busy_b), .vec_cnt(vec_cnt_b)
    );

    // Byte j of lane `lane` in vector v; vector 0 gives lane i bytes {i*8+7..i*8}
    function automatic logic [7:0] vbyte(input int v, input int lane, input int j);
        return 8'((v * 32 + lane * 8 + j) & 255);
    endfunction

    function automatic logic [63:0] word(input int v, input int lane);
        logic [63:0] r;
        for (int j = 0; j < 8; j++) r[j*8 +: 8] = vbyte(v, lane, j);
        return r;
    endfunction

    function automatic logic [127:0] exp_beat(input int v, input int k, input int w);
        logic [127:0] r = '0;
        for (int lane = 0; lane < 4; lane++)
            for (int b = 0; b < w; b++)
                r[(lane*w + b)*8 +: 8] = vbyte(v, lane, k*w + b);
        return r;
    endfunction

    exp_t qa[$];
    exp_t qb[$];
    int   supplied_a = 0, reads_a = 0, supplied_b = 0, reads_b = 0;
    logic vld_a [RA];
    int   vi_a  [RA];
    logic vld_b [RB];
    int   vi_b  [RB];
    logic [255:0] gar_a, gar_b;

    assign empty_a = (supplied_a == reads_a) ? 4'hf : force_a;
    assign empty_b = (supplied_b == reads_b) ? 4'hf : 4'h0;

    always @(posedge clk) begin
        for (int j = 0; j < 8; j++) begin
            gar_a[j*32 +: 32] <= $urandom;
            gar_b[j*32 +: 32] <= $urandom;
        end
    end

    // FIFO models: a served read queues its expected beats and arrival cycles
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < RA; s++) begin vld_a[s] <= 1'b0; vi_a[s] <= 0; end
            for (int s = 0; s < RB; s++) begin vld_b[s] <= 1'b0; vi_b[s] <= 0; end
        end else begin
            vld_a[0] <= &rd_en_a;
            vi_a[0]  <= reads_a;
            for (int s = 1; s < RA; s++) begin vld_a[s] <= vld_a[s-1]; vi_a[s] <= vi_a[s-1]; end
            vld_b[0] <= &rd_en_b;
            vi_b[0]  <= reads_b;
            for (int s = 1; s < RB; s++) begin vld_b[s] <= vld_b[s-1]; vi_b[s] <= vi_b[s-1]; end
            if (&rd_en_a) begin
                reads_a <= reads_a + 1;
                for (int k = 0; k < NA; k++)
                    qa.push_back('{data: exp_beat(reads_a, k, WA), cyc: cyc + RA + 2 + OA + k});
            end
            if (&rd_en_b) begin
                reads_b <= reads_b + 1;
                for (int k = 0; k < NB; k++)
                    qb.push_back('{data: exp_beat(reads_b, k, WB), cyc: cyc + RB + 2 + OB + k});
            end
        end
    end

    // Outside the valid cycle the FIFO outputs random junk
    always_comb begin
        for (int l = 0; l < 4; l++) begin
            dout_a[l*64 +: 64] = vld_a[RA-1] ? word(vi_a[RA-1], l) : gar_a[l*64 +: 64];
            dout_b[l*64 +: 64] = vld_b[RB-1] ? word(vi_b[RB-1], l) : gar_b[l*64 +: 64];
        end
    end

    bit           chk_time_a = 1'b1;
    int           shift_a = 0;
    int           beats_a = 0, vbeats_a = 0, beats_b = 0, nrd_b = 0, last_rd_b = 0;
    logic [63:0]  last_din_a = '0;
    logic [127:0] last_din_b = '0;

    always begin
        exp_t e;
        @(negedge clk);
        if (rst_n) begin
            if (wr_en_a) begin
                checks++;
                assert (qa.size() > 0) else begin errors++; $error("FAIL a_unexpected_beat got din=%h expected no beat", din_a); end
                if (qa.size() > 0) begin
                    e = qa.pop_front();
                    checks++;
                    assert (din_a === e.data[63:0]) else begin errors++; $error("FAIL a_beat_data got %h expected %h", din_a, e.data[63:0]); end
                    if (chk_time_a) begin
                        checks++;
                        assert (cyc === e.cyc + shift_a) else begin errors++; $error("FAIL a_beat_cycle got %0d expected %0d", cyc, e.cyc + shift_a); end
                    end
                end
                last_din_a = din_a;
                beats_a++;
                vbeats_a++;
            end else begin
                checks++;
                assert (din_a === last_din_a) else begin errors++; $error("FAIL a_din_hold got %h expected %h", din_a, last_din_a); end
            end
            checks++;
            assert (rd_en_a === 4'h0 || rd_en_a === 4'hf) else begin errors++; $error("FAIL a_rd_en_uniform got %b expected 0000 or 1111", rd_en_a); end
            if (rd_en_a !== 4'h0) begin
                checks++;
                assert ({busy_a, empty_a} === 5'b0) else begin errors++; $error("FAIL a_read_legal got busy=%b empty=%b expected 0/0000", busy_a, empty_a); end
            end
        end
    end

    always begin
        exp_t e;
        @(negedge clk);
        if (rst_n) begin
            if (wr_en_b) begin
                checks++;
                assert (qb.size() > 0) else begin errors++; $error("FAIL b_unexpected_beat got din=%h expected no beat", din_b); end
                if (qb.size() > 0) begin
                    e = qb.pop_front();
                    checks++;
                    assert (din_b === e.data) else begin errors++; $error("FAIL b_beat_data got %h expected %h", din_b, e.data); end
                    checks++;
                    assert (cyc === e.cyc) else begin errors++; $error("FAIL b_beat_cycle got %0d expected %0d", cyc, e.cyc); end
                end
                last_din_b = din_b;
                beats_b++;
            end else begin
                checks++;
                assert (din_b === last_din_b) else begin errors++; $error("FAIL b_din_hold got %h expected %h", din_b, last_din_b); end
            end
            if (&rd_en_b) begin
                if (nrd_b > 0) begin
                    checks++;
                    assert (cyc - last_rd_b === 6) else begin errors++; $error("FAIL b_vector_period got %0d expected 6", cyc - last_rd_b); end
                end
                last_rd_b = cyc;
                nrd_b++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin errors++; $error("FAIL %s got %0h expected %0h", tag, got, exp); end
    endtask

    task automatic drain_a(input int maxc, input string tag);
        bit done = 1'b0;
        for (int i = 0; i < maxc && !done; i++) begin
            step();
            if (qa.size() == 0 && busy_a === 1'b0 && supplied_a == reads_a) done = 1'b1;
        end
        checks++;
        assert (done === 1'b1) else begin errors++; $error("FAIL %s_timeout got pending=%0d expected 0", tag, qa.size()); end
    endtask

    task automatic drain_b(input int maxc, input string tag);
        bit done = 1'b0;
        for (int i = 0; i < maxc && !done; i++) begin
            step();
            if (qb.size() == 0 && busy_b === 1'b0 && supplied_b == reads_b) done = 1'b1;
        end
        checks++;
        assert (done === 1'b1) else begin errors++; $error("FAIL %s_timeout got pending=%0d expected 0", tag, qb.size()); end
    endtask

    // Returns just after the negedge on which the n-th beat of the vector is visible
    task automatic wait_vbeats_a(input int n, input int maxc, input string tag);
        bit done = 1'b0;
        for (int i = 0; i < maxc && !done; i++) begin
            @(negedge clk);
            #1;
            if (vbeats_a >= n) done = 1'b1;
        end
        checks++;
        assert (done === 1'b1) else begin errors++; $error("FAIL %s_beat_timeout got %0d expected %0d", tag, vbeats_a, n); end
    endtask

    initial begin
        int rr;
        pf_a = 1'b0;
        pf_b = 1'b0;
        force_a = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_en_a", rd_en_a, 0);
        chk("rst_wr_en_a", wr_en_a, 0);
        chk("rst_din_a", din_a, 0);
        chk("rst_busy_a", busy_a, 0);
        chk("rst_vec_cnt_a", vec_cnt_a, 0);
        chk("rst_wr_en_b", wr_en_b, 0);
        chk("rst_din_b", din_b, 0);
        chk("rst_vec_cnt_b", vec_cnt_b, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();

        // single vector
        vbeats_a = 0;
        supplied_a = 1;
        drain_a(40, "single");
        chk("single_vec_cnt", vec_cnt_a, 1);
        chk("single_reads", reads_a, 1);
        chk("single_beats", vbeats_a, 4);

        // backpressure for 3 cycles right after beat 1
        vbeats_a = 0;
        supplied_a++;
        wait_vbeats_a(2, 20, "bp");
        pf_a = 1'b1;
        shift_a = 3;
        repeat (3) @(posedge clk);
        #1;
        pf_a = 1'b0;
        drain_a(40, "bp");
        shift_a = 0;
        chk("bp_vec_cnt", vec_cnt_a, 2);
        chk("bp_beats", vbeats_a, 4);

        // prog_full does not block the read, only the beats
        vbeats_a = 0;
        chk_time_a = 1'b0;
        pf_a = 1'b1;
        rr = reads_a;
        supplied_a++;
        repeat (6) step();
        chk("pf_idle_read", reads_a, rr + 1);
        chk("pf_idle_no_beat", vbeats_a, 0);
        pf_a = 1'b0;
        drain_a(40, "pf_idle");
        chk_time_a = 1'b1;
        chk("pf_idle_vec_cnt", vec_cnt_a, 3);

        // one lane empty holds off every lane
        force_a = 4'b0100;
        rr = reads_a;
        supplied_a++;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("lane_empty_rd_en", rd_en_a, 0);
        end
        force_a = 4'h0;
        #1;
        chk("lane_full_rd_en", rd_en_a, 4'hf);
        drain_a(40, "lane_empty");
        chk("lane_empty_reads", reads_a, rr + 1);
        chk("lane_empty_vec_cnt", vec_cnt_a, 4);

        // reset in the middle of SEND
        vbeats_a = 0;
        supplied_a++;
        wait_vbeats_a(2, 20, "rst_mid");
        rst_n = 1'b0;
        #1;
        qa.delete();
        last_din_a = '0;
        chk("rst_mid_wr_en", wr_en_a, 0);
        chk("rst_mid_din", din_a, 0);
        chk("rst_mid_rd_en", rd_en_a, 0);
        chk("rst_mid_busy", busy_a, 0);
        chk("rst_mid_vec_cnt", vec_cnt_a, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) step();
        chk("rst_mid_no_more_beats", vbeats_a, 2);
        chk("rst_mid_vec_cnt_after", vec_cnt_a, 0);
        chk("rst_mid_idle", busy_a, 0);

        // 100 back-to-back vectors on the W=4 RD_LAT=3 OUT_REGS=2 instance
        supplied_b = 100;
        drain_b(100 * 6 + 60, "sweep");
        chk("sweep_vec_cnt", vec_cnt_b, 100);
        chk("sweep_beats", beats_b, 200);
        chk("sweep_reads", nrd_b, 100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
